// File: rtl/fetch_debug_controller.sv
// Debug-link sequencer for the fetch stage: decodes UART command bytes, loads
// program words into instruction memory, and gates run/step/reset of the pipeline.
module fetch_debug_controller #(
  parameter int NB_INSTR = 32,
  parameter int N_ADDR   = 2048,
  parameter int NB_ADDR  = 16,
  parameter int NB_BYTE  = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic [NB_ADDR-1:0]  o_instrmem_addr,
  output logic [NB_INSTR-1:0] o_instrmem_data,
  output logic [3:0]          o_instrmem_we,
  output logic                o_valid,
  output logic                o_cpu_reset,
  input  logic                i_halt,
  output logic                o_busy
);

  localparam int NB_IDX         = $clog2(N_ADDR);
  localparam int NB_LEN         = 2 * NB_BYTE;
  localparam int BYTES_PER_WORD = NB_INSTR / NB_BYTE;
  localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(1);
  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(2);
  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(3);
  localparam logic [NB_BYTE-1:0] CMD_RESET = NB_BYTE'(4);
  localparam logic [NB_BYTE-1:0] CMD_BREAK = NB_BYTE'(5);
  localparam logic [NB_BYTE-1:0] ACK_FLAG  = {1'b1, {(NB_BYTE-1){1'b0}}};
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_RUN,
    ST_STEP,
    ST_CRST,
    ST_ACK
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [NB_BYTE-1:0]  cmd_reg;
  logic [NB_BYTE-1:0]  len_hi_reg;
  logic [NB_LEN-1:0]   remaining_reg;
  logic [NB_IDX-1:0]   word_idx_reg;
  logic [NB_BCNT-1:0]  byte_cnt_reg;
  logic [NB_INSTR-1:0] word_reg;
  logic [NB_INSTR-1:0] word_shift;
  logic [NB_LEN-1:0]   len_rx;
  logic                rx_is_cmd;

  assign len_rx = {len_hi_reg, i_rx_data};

  // Big-endian assembly: each new byte enters lane 0 and older bytes move up.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign word_shift[NB_BYTE-1:0] = i_rx_data;
      end else begin : g_shift
        assign word_shift[gi*NB_BYTE +: NB_BYTE] = word_reg[(gi-1)*NB_BYTE +: NB_BYTE];
      end
    end
  endgenerate

  always_comb begin
    rx_is_cmd = 1'b0;
    case (i_rx_data)
      CMD_LOAD, CMD_RUN, CMD_STEP, CMD_RESET: rx_is_cmd = 1'b1;
      default:                                rx_is_cmd = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD:  state_next = ST_LEN_HI;
            CMD_RUN:   state_next = ST_RUN;
            CMD_STEP:  state_next = ST_STEP;
            CMD_RESET: state_next = ST_CRST;
            default:   state_next = ST_IDLE;
          endcase
        end
      end
      ST_LEN_HI: begin
        if (i_rx_valid) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (i_rx_valid) state_next = (len_rx == '0) ? ST_ACK : ST_DATA;
      end
      ST_DATA: begin
        if (i_rx_valid && (byte_cnt_reg == LAST_BYTE)) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = (remaining_reg == NB_LEN'(1)) ? ST_ACK : ST_DATA;
      end
      ST_RUN: begin
        if (i_halt || (i_rx_valid && (i_rx_data == CMD_BREAK))) state_next = ST_ACK;
      end
      ST_STEP:  state_next = ST_ACK;
      ST_CRST:  state_next = ST_ACK;
      ST_ACK: begin
        if (i_tx_ready) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath registers: command, length, word index and word assembly
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cmd_reg       <= '0;
      len_hi_reg    <= '0;
      remaining_reg <= '0;
      word_idx_reg  <= '0;
      byte_cnt_reg  <= '0;
      word_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_rx_valid && rx_is_cmd) begin
            cmd_reg <= i_rx_data;
            if (i_rx_data == CMD_LOAD) begin
              word_idx_reg <= '0;
              byte_cnt_reg <= '0;
            end
          end
        end
        ST_LEN_HI: begin
          if (i_rx_valid) len_hi_reg <= i_rx_data;
        end
        ST_LEN_LO: begin
          if (i_rx_valid) remaining_reg <= len_rx;
        end
        ST_DATA: begin
          if (i_rx_valid) begin
            word_reg     <= word_shift;
            byte_cnt_reg <= (byte_cnt_reg == LAST_BYTE) ? '0 : byte_cnt_reg + NB_BCNT'(1);
          end
        end
        ST_WRITE: begin
          // Index is NB_IDX bits wide, so it wraps modulo N_ADDR on its own.
          word_idx_reg  <= word_idx_reg + NB_IDX'(1);
          remaining_reg <= remaining_reg - NB_LEN'(1);
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_tx_data       = '0;
    o_tx_valid      = 1'b0;
    o_instrmem_addr = '0;
    o_instrmem_data = '0;
    o_instrmem_we   = 4'h0;
    o_valid         = 1'b0;
    o_cpu_reset     = 1'b0;
    o_busy          = (state_reg != ST_IDLE);
    case (state_reg)
      ST_WRITE: begin
        o_instrmem_addr = NB_ADDR'(word_idx_reg);
        o_instrmem_data = word_reg;
        o_instrmem_we   = 4'hF;
      end
      ST_RUN, ST_STEP: o_valid = 1'b1;
      ST_CRST:         o_cpu_reset = 1'b1;
      ST_ACK: begin
        o_tx_valid = 1'b1;
        o_tx_data  = cmd_reg | ACK_FLAG;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_debug_controller.sv
// Scoreboard bench for fetch_debug_controller: expected memory writes and ack
// bytes are queued at stimulus time and popped when the DUT produces them.
module tb_fetch_debug_controller;

  localparam int NB_INSTR = 32;
  localparam int N_ADDR   = 2048;
  localparam int NB_ADDR  = 16;
  localparam int NB_BYTE  = 8;

  logic                i_clock = 1'b0;
  logic                i_reset;
  logic [NB_BYTE-1:0]  i_rx_data;
  logic                i_rx_valid;
  logic [NB_BYTE-1:0]  o_tx_data;
  logic                o_tx_valid;
  logic                i_tx_ready;
  logic [NB_ADDR-1:0]  o_instrmem_addr;
  logic [NB_INSTR-1:0] o_instrmem_data;
  logic [3:0]          o_instrmem_we;
  logic                o_valid;
  logic                o_cpu_reset;
  logic                i_halt;
  logic                o_busy;

  fetch_debug_controller #(
    .NB_INSTR(NB_INSTR), .N_ADDR(N_ADDR), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_instrmem_addr(o_instrmem_addr), .o_instrmem_data(o_instrmem_data),
    .o_instrmem_we(o_instrmem_we), .o_valid(o_valid), .o_cpu_reset(o_cpu_reset),
    .i_halt(i_halt), .o_busy(o_busy)
  );

  always #5 i_clock = ~i_clock;

  int checks   = 0;
  int failures = 0;

  logic [47:0] wr_q[$];    // {addr, data}
  logic [7:0]  tx_q[$];
  logic [31:0] load_q[$];
  int valid_cnt = 0;
  int rst_cnt   = 0;
  int we_cnt    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampling on the falling edge
  always @(negedge i_clock) begin
    if (o_valid) valid_cnt++;
    if (o_cpu_reset) rst_cnt++;
    if (o_instrmem_we != 4'h0) begin
      logic [47:0] e;
      we_cnt++;
      if (wr_q.size() == 0) begin
        check("we_unexpected", {60'd0, o_instrmem_we}, 64'd0);
      end else begin
        e = wr_q.pop_front();
        check("we_value", {60'd0, o_instrmem_we}, 64'hF);
        check("wr_addr", {48'd0, o_instrmem_addr}, {48'd0, e[47:32]});
        check("wr_data", {32'd0, o_instrmem_data}, {32'd0, e[31:0]});
        $display("write addr=%0d data=0x%08h", o_instrmem_addr, o_instrmem_data);
      end
    end
    if (o_tx_valid && i_tx_ready) begin
      if (tx_q.size() == 0) begin
        check("tx_unexpected", {63'd0, o_tx_valid}, 64'd0);
      end else begin
        logic [7:0] t;
        t = tx_q.pop_front();
        check("tx_byte", {56'd0, o_tx_data}, {56'd0, t});
        $display("ack tx=0x%02h", o_tx_data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clock); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clock); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    while (tx_q.size() != 0 && k < 200) begin
      @(posedge i_clock); #1;
      k++;
    end
    if (k >= 200) check({tag, "_ack_timeout"}, 64'd1, {63'd0, o_tx_valid & 1'b0});
    @(posedge i_clock); #1;
    check({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
  endtask

  task automatic do_load(input string tag);
    int n = load_q.size();
    tx_q.push_back(8'h81);
    send_byte(8'h01);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w = load_q[i];
      wr_q.push_back({16'(i % N_ADDR), w});
      for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
    end
    wait_ack(tag);
    check({tag, "_wr_pending"}, 64'(wr_q.size()), 64'd0);
    load_q.delete();
  endtask

  initial begin
    int snap;
    i_reset = 1'b1; i_rx_data = '0; i_rx_valid = 1'b0; i_halt = 1'b0; i_tx_ready = 1'b1;
    repeat (3) @(posedge i_clock);
    #1 i_reset = 1'b0;
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_tx_valid", {63'd0, o_tx_valid}, 64'd0);
    check("rst_we", {60'd0, o_instrmem_we}, 64'd0);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_cpu_reset", {63'd0, o_cpu_reset}, 64'd0);

    // Two-word load
    load_q.push_back(32'hDEADBEEF);
    load_q.push_back(32'h0000002A);
    snap = we_cnt;
    do_load("load2");
    check("load2_we_count", 64'(we_cnt - snap), 64'd2);

    // Zero-length load
    snap = we_cnt;
    do_load("load0");
    check("load0_we_count", 64'(we_cnt - snap), 64'd0);

    // N_ADDR+1 words: last one wraps to address 0
    for (int i = 0; i < N_ADDR + 1; i++) load_q.push_back($urandom);
    snap = we_cnt;
    do_load("loadwrap");
    check("loadwrap_we_count", 64'(we_cnt - snap), 64'(N_ADDR + 1));

    // RUN, halted on the 11th run cycle, ack held off for 5 cycles
    snap = valid_cnt;
    tx_q.push_back(8'h82);
    send_byte(8'h02);
    i_tx_ready = 1'b0;
    repeat (10) @(posedge i_clock);
    #1 i_halt = 1'b1;
    @(posedge i_clock); #1 i_halt = 1'b0;
    check("halt_valid_low", {63'd0, o_valid}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("halt_tx_held", {63'd0, o_tx_valid}, 64'd1);
      check("halt_tx_data", {56'd0, o_tx_data}, 64'h82);
      @(posedge i_clock); #1;
    end
    i_tx_ready = 1'b1;
    wait_ack("halt");
    check("halt_valid_count", 64'(valid_cnt - snap), 64'd11);

    // RUN with BREAK; a STEP byte mid-run is ignored
    tx_q.push_back(8'h82);
    send_byte(8'h02);
    check("brk_valid_high", {63'd0, o_valid}, 64'd1);
    repeat (8) @(posedge i_clock);
    send_byte(8'h03);
    check("brk_still_running", {63'd0, o_valid}, 64'd1);
    repeat (8) @(posedge i_clock);
    send_byte(8'h05);
    check("brk_valid_low", {63'd0, o_valid}, 64'd0);
    wait_ack("brk");

    // Three single steps
    for (int s = 0; s < 3; s++) begin
      snap = valid_cnt;
      tx_q.push_back(8'h83);
      send_byte(8'h03);
      check("step_valid_t1", {63'd0, o_valid}, 64'd1);
      check("step_tx_t1", {63'd0, o_tx_valid}, 64'd0);
      @(posedge i_clock); #1;
      check("step_valid_t2", {63'd0, o_valid}, 64'd0);
      check("step_tx_t2", {63'd0, o_tx_valid}, 64'd1);
      wait_ack("step");
      check("step_valid_count", 64'(valid_cnt - snap), 64'd1);
    end

    // Pipeline reset command
    snap = rst_cnt;
    tx_q.push_back(8'h84);
    send_byte(8'h04);
    check("crst_pulse", {63'd0, o_cpu_reset}, 64'd1);
    @(posedge i_clock); #1;
    check("crst_pulse_end", {63'd0, o_cpu_reset}, 64'd0);
    check("crst_tx", {63'd0, o_tx_valid}, 64'd1);
    wait_ack("crst");
    check("crst_count", 64'(rst_cnt - snap), 64'd1);

    // Unknown byte is ignored
    send_byte(8'h7F);
    for (int i = 0; i < 3; i++) begin
      check("unknown_busy", {63'd0, o_busy}, 64'd0);
      @(posedge i_clock); #1;
    end

    // Reset in the middle of a word, then a fresh one-word load
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    check("mid_busy", {63'd0, o_busy}, 64'd1);
    @(posedge i_clock); #1 i_reset = 1'b1;
    @(posedge i_clock); #1 i_reset = 1'b0;
    check("mid_rst_busy", {63'd0, o_busy}, 64'd0);
    check("mid_rst_we", {60'd0, o_instrmem_we}, 64'd0);
    check("mid_rst_addr", {48'd0, o_instrmem_addr}, 64'd0);
    check("mid_rst_tx", {63'd0, o_tx_valid}, 64'd0);
    load_q.push_back(32'h11223344);
    do_load("fresh");

    check("end_tx_queue", 64'(tx_q.size()), 64'd0);
    check("end_wr_queue", 64'(wr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
